zoom_window_reader: RTL and testbench
=====================================

ZOOM_WINDOW_READER -- requirements
Module: zoom_window_reader

Interface
REQ-001 Params: IMG_W 160, source image width in pixels; IMG_H 120, source image height in lines; SCREEN_W 640, display width; SCREEN_H 480, display height; PIX_W 8, pixel width; PPW 2, pixels per RAM word; ADDR_W 16, RAM address width.
REQ-002 clock  in  1  system clock, 2x pixel rate.
REQ-003 reset_n  in  1  asynchronous reset, active low.
REQ-004 pixel_en  in  1  one-cycle strobe per displayed pixel (every 2nd clock).
REQ-005 next_x  in  10  column of the pixel being fetched.
REQ-006 next_y  in  10  line of the pixel being fetched.
REQ-007 zoom_sel  in  2  requested zoom: 0=1x, 1=2x, 2=4x, 3=reserved (treated as 1x).
REQ-008 mem_q  in  PIX_W*PPW  RAM read data, 1-cycle latency.
REQ-009 mem_addr  out  ADDR_W  RAM word address.
REQ-010 mem_rden  out  1  RAM read enable.
REQ-011 color_out  out  PIX_W  pixel to the VGA module.
REQ-012 color_valid  out  1  high for one cycle when color_out updates.
REQ-013 zoom_active  out  2  zoom currently applied.

Function
REQ-014 Zoom factor Z (1/2/4) SHALL be latched from zoom_sel only at frame start (pixel_en with next_x==0, next_y==0); all other changes are ignored until the next frame start.
REQ-015 Window SHALL be centred: X0=(SCREEN_W-IMG_W*Z)/2, Y0=(SCREEN_H-IMG_H*Z)/2, width IMG_W*Z, height IMG_H*Z; X0/Y0 per Z are constants selected by a mux, with no runtime multiply.
REQ-016 FSM states: BLANK (outside window), LINE (inside window row), HOLD (between window rows); BLANK->LINE at first in-window pixel_en of frame; LINE->HOLD when next_x leaves window; HOLD->LINE at next in-window pixel_en; any->BLANK when next_y >= Y0+IMG_H*Z or at frame start.
REQ-017 Source column = (next_x-X0)>>log2(Z); word = column/PPW; lane = column%PPW; lane 0 SHALL be the most significant PIX_W bits of mem_q.
REQ-018 Row base SHALL be an accumulator cleared at frame start and incremented by IMG_W/PPW words once every Z window lines, on the LINE->HOLD transition; mem_addr = row base + word.
REQ-019 On an in-window pixel_en, mem_addr and mem_rden=1 SHALL be registered that cycle; color_out SHALL be registered from the selected lane of mem_q 2 cycles after pixel_en, with color_valid=1 for that cycle.
REQ-020 Out-of-window pixel_en SHALL yield mem_rden=0 and color_out=0 (see REQ-026) with the same 2-cycle latency.
REQ-021 Row base SHALL NOT exceed IMG_W*IMG_H/PPW-1; the final increment after the last window row is suppressed.
REQ-022 pixel_en low: outputs hold, mem_rden=0, color_valid=0.

Reset
REQ-023 On reset_n low, asynchronously: FSM=BLANK, row base=0, mem_addr=0, mem_rden=0, color_out=0, color_valid=0, zoom_active=0 (1x).
REQ-024 Reset deasserted mid-frame: block stays BLANK until the next frame start, then operates normally.

Configuration
REQ-025 Macro ZOOM_BORDER_EN SHALL be defined or undefined at compile time.
REQ-026 With it: out-of-window pixels output parameter BORDER_COLOR (default 8'h25). Without it: out-of-window pixels output 0 and BORDER_COLOR is unused.

Structure
REQ-027 Package zoom_pkg SHALL hold the zoom encoding enum, the FSM state typedef, and the per-zoom X0/Y0 constant functions.
REQ-028 Sub-module win_addr_gen SHALL contain the row-base accumulator and column/word/lane computation; the top holds the FSM, the zoom latch and the output pipeline.

Verification
REQ-029 Zoom 1x, pixel_en at (240,180) -> mem_addr=0, mem_rden=1; 2 cycles later color_out=mem_q[15:8]; (241,180) -> addr 0, lane 1.
REQ-030 Zoom 2x: (160,120),(161,120) -> addr 0 lane 0 twice; (162,120) -> addr 0 lane 1; (164,120) -> addr 1; line 122 first pixel -> addr 80.
REQ-031 Zoom 4x, full frame -> every pixel in window; last pixel (639,479) -> addr 9599, lane 1; no address above 9599.
REQ-032 zoom_sel changed 1->2 at (300,200) -> zoom_active stays 1 until the next (0,0) pixel_en, then 2.
REQ-033 (0,0) with zoom 2x -> mem_rden=0, color_out=0, or 8'h25 when ZOOM_BORDER_EN is defined.
REQ-034 reset_n pulsed low at (300,250) -> all outputs 0 immediately; no mem_rden until the next frame start.

Source files
------------

// File: rtl/zoom_window_reader_pkg.sv
// Shared types and window geometry helpers for the zoom window reader.
// The zoom encoding doubles as log2 of the zoom factor (0->1x, 1->2x, 2->4x).
package zoom_pkg;

    typedef enum logic [1:0] {
        ZOOM_1X   = 2'd0,
        ZOOM_2X   = 2'd1,
        ZOOM_4X   = 2'd2,
        ZOOM_RSVD = 2'd3
    } zoom_e;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_LINE  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Reserved encoding falls back to 1x.
    function automatic zoom_e zoom_decode(input logic [1:0] sel);
        return (sel == 2'd3) ? ZOOM_1X : zoom_e'(sel);
    endfunction

    function automatic int zoom_factor(input zoom_e z);
        case (z)
            ZOOM_2X: return 2;
            ZOOM_4X: return 4;
            default: return 1;
        endcase
    endfunction

    // Left edge of the centred window; evaluated at elaboration only.
    function automatic int win_x0(input zoom_e z, input int screen_w, input int img_w);
        return (screen_w - img_w * zoom_factor(z)) / 2;
    endfunction

    // Top edge of the centred window; evaluated at elaboration only.
    function automatic int win_y0(input zoom_e z, input int screen_h, input int img_h);
        return (screen_h - img_h * zoom_factor(z)) / 2;
    endfunction

endpackage

// File: rtl/zoom_window_reader_if.sv
// Frame-buffer RAM read port: word address, read enable, 1-cycle read data.
interface zoom_window_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              rden;
    logic [DATA_W-1:0] q;

    modport master (output addr, output rden, input q);
    modport slave  (input addr, input rden, output q);
endinterface

// File: rtl/zoom_window_reader_win_addr_gen.sv
// Source address generation: row-base accumulator plus column/word/lane split.
// Address and lane are combinational so the top can register them on the
// same pixel_en cycle; the frame-start pixel sees a row base of zero.
module win_addr_gen
    import zoom_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int PPW    = 2,
    parameter int ADDR_W = 16,
    parameter int LANE_W = (PPW > 1) ? $clog2(PPW) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  zoom_e             zoom,
    input  logic              clear,
    input  logic              line_end,
    input  logic              last_row,
    input  logic [9:0]        x_off,
    output logic [ADDR_W-1:0] addr,
    output logic [LANE_W-1:0] lane
);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W / PPW);
    localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'((IMG_H - 1) * (IMG_W / PPW));
    localparam logic [9:0]        PPW_C    = 10'(PPW);

    logic [ADDR_W-1:0] row_base;
    logic [1:0]        sub_line;
    logic [1:0]        sub_last;
    logic [9:0]        column;
    logic [9:0]        word;
    logic [ADDR_W-1:0] row_cur;

    // Column/word/lane split and final address for the current pixel.
    always_comb begin
        column   = x_off >> zoom;
        word     = column / PPW_C;
        lane     = LANE_W'(column % PPW_C);
        row_cur  = clear ? '0 : row_base;
        addr     = row_cur + ADDR_W'(word);
        case (zoom)
            ZOOM_2X: sub_last = 2'd1;
            ZOOM_4X: sub_last = 2'd3;
            default: sub_last = 2'd0;
        endcase
    end

    // Advance one source row every Z window lines; never past the last row.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_base <= '0;
            sub_line <= '0;
        end else if (clear) begin
            row_base <= '0;
            sub_line <= '0;
        end else if (line_end) begin
            if (sub_line == sub_last) begin
                sub_line <= '0;
                if (!last_row && (row_base != ROW_MAX))
                    row_base <= row_base + ROW_STEP;
            end else begin
                sub_line <= sub_line + 2'd1;
            end
        end
    end
endmodule

// File: rtl/zoom_window_reader.sv
// Zoom window reader: fetches source pixels for a centred 1x/2x/4x window
// and delivers them to the display two cycles after each pixel_en.
// Build option: define ZOOM_BORDER_EN to paint out-of-window pixels with
// BORDER_COLOR instead of black.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_BLANK | outside the window (or not yet synced to a frame)
// ST_LINE  | inside a window row
// ST_HOLD  | between window rows, after a row's last column
module zoom_window_reader
    import zoom_pkg::*;
#(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PIX_W    = 8,
    parameter int PPW      = 2,
    parameter int ADDR_W   = 16
`ifdef ZOOM_BORDER_EN
    , parameter logic [PIX_W-1:0] BORDER_COLOR = 8'h25
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 pixel_en,
    input  logic [9:0]           next_x,
    input  logic [9:0]           next_y,
    input  logic [1:0]           zoom_sel,
    zoom_window_reader_if.master mem,
    output logic [PIX_W-1:0]     color_out,
    output logic                 color_valid,
    output logic [1:0]           zoom_active
);
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

`ifdef ZOOM_BORDER_EN
    localparam logic [PIX_W-1:0] BORDER_PIX = BORDER_COLOR;
`else
    localparam logic [PIX_W-1:0] BORDER_PIX = '0;
`endif

    localparam logic [9:0] X0_1 = 10'(win_x0(ZOOM_1X, SCREEN_W, IMG_W));
    localparam logic [9:0] X0_2 = 10'(win_x0(ZOOM_2X, SCREEN_W, IMG_W));
    localparam logic [9:0] X0_4 = 10'(win_x0(ZOOM_4X, SCREEN_W, IMG_W));
    localparam logic [9:0] Y0_1 = 10'(win_y0(ZOOM_1X, SCREEN_H, IMG_H));
    localparam logic [9:0] Y0_2 = 10'(win_y0(ZOOM_2X, SCREEN_H, IMG_H));
    localparam logic [9:0] Y0_4 = 10'(win_y0(ZOOM_4X, SCREEN_H, IMG_H));
    localparam logic [9:0] XE_1 = X0_1 + 10'(IMG_W);
    localparam logic [9:0] XE_2 = X0_2 + 10'(IMG_W * 2);
    localparam logic [9:0] XE_4 = X0_4 + 10'(IMG_W * 4);
    localparam logic [9:0] YE_1 = Y0_1 + 10'(IMG_H);
    localparam logic [9:0] YE_2 = Y0_2 + 10'(IMG_H * 2);
    localparam logic [9:0] YE_4 = Y0_4 + 10'(IMG_H * 4);

    state_e            state, state_nxt;
    zoom_e             zoom_q, zoom_eff;
    logic              armed, active, frame_start;
    logic [9:0]        x0, y0, x_end, y_end;
    logic              in_win, at_last_col, last_row;
    logic              fetch, row_done;
    logic [ADDR_W-1:0] gen_addr;
    logic [LANE_W-1:0] gen_lane;
    logic              v1, w1, v2, w2;
    logic [LANE_W-1:0] l1, l2;
    logic [PIX_W-1:0]  lane_pix;

    // The frame-start pixel already uses the newly requested zoom.
    assign frame_start = pixel_en && (next_x == 10'd0) && (next_y == 10'd0);
    assign zoom_eff    = frame_start ? zoom_decode(zoom_sel) : zoom_q;
    assign active      = armed || frame_start;
    assign zoom_active = zoom_q;

    // Window geometry for the effective zoom, plus position classification.
    always_comb begin
        x0    = X0_1;
        y0    = Y0_1;
        x_end = XE_1;
        y_end = YE_1;
        case (zoom_eff)
            ZOOM_2X: begin x0 = X0_2; y0 = Y0_2; x_end = XE_2; y_end = YE_2; end
            ZOOM_4X: begin x0 = X0_4; y0 = Y0_4; x_end = XE_4; y_end = YE_4; end
            default: ;
        endcase
        in_win      = (next_x >= x0) && (next_x < x_end) && (next_y >= y0) && (next_y < y_end);
        at_last_col = (next_x == x_end - 10'd1);
        last_row    = (next_y == y_end - 10'd1);
    end

    // Zoom is only sampled at frame start; armed blocks fetches after a mid-frame reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zoom_q <= ZOOM_1X;
            armed  <= 1'b0;
        end else if (frame_start) begin
            zoom_q <= zoom_decode(zoom_sel);
            armed  <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_BLANK;
        else          state <= state_nxt;
    end

    // FSM next state; a row ends on its last in-window column.
    always_comb begin
        state_nxt = state;
        if (pixel_en) begin
            if (!active || (next_y >= y_end) || (frame_start && !in_win))
                state_nxt = ST_BLANK;
            else if (in_win)
                state_nxt = at_last_col ? ST_HOLD : ST_LINE;
            else if (state == ST_LINE)
                state_nxt = ST_HOLD;
        end
    end

    // FSM outputs: fetch request and end-of-row strobe.
    always_comb begin
        fetch    = pixel_en && active && in_win;
        row_done = fetch && at_last_col && (state != ST_BLANK || frame_start || in_win);
    end

    win_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PPW   (PPW),
        .ADDR_W(ADDR_W),
        .LANE_W(LANE_W)
    ) u_addr (
        .clock   (clock),
        .reset_n (reset_n),
        .zoom    (zoom_eff),
        .clear   (frame_start),
        .line_end(row_done),
        .last_row(last_row),
        .x_off   (next_x - x0),
        .addr    (gen_addr),
        .lane    (gen_lane)
    );

    // Lane 0 sits in the most significant bits of the RAM word.
    always_comb begin
        lane_pix = '0;
        for (int i = 0; i < PPW; i++)
            if (LANE_W'(i) == l2) lane_pix = mem.q[(PPW - 1 - i) * PIX_W +: PIX_W];
    end

    // Read issue, two-stage tracking of the request, then the colour register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem.addr    <= '0;
            mem.rden    <= 1'b0;
            v1          <= 1'b0;
            w1          <= 1'b0;
            l1          <= '0;
            v2          <= 1'b0;
            w2          <= 1'b0;
            l2          <= '0;
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            mem.rden <= fetch;
            if (fetch) mem.addr <= gen_addr;
            v1          <= pixel_en;
            w1          <= fetch;
            l1          <= gen_lane;
            v2          <= v1;
            w2          <= w1;
            l2          <= l1;
            color_valid <= v2;
            if (v2) color_out <= w2 ? lane_pix : BORDER_PIX;
        end
    end
endmodule

// File: tb/tb_zoom_window_reader.sv
// Scoreboard bench for zoom_window_reader: the driver issues directed pixels,
// checks the registered read request, and queues the expected colour; a
// monitor pops and compares whenever color_valid is seen.
module tb_zoom_window_reader;
    import zoom_pkg::*;

`ifdef ZOOM_BORDER_EN
    localparam logic [7:0] BORDER = 8'h25;
`else
    localparam logic [7:0] BORDER = 8'h00;
`endif

    typedef struct {
        logic [7:0] color;
        int         cyc;
        string      tag;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pixel_en = 1'b0;
    logic [9:0] next_x = '0;
    logic [9:0] next_y = '0;
    logic [1:0] zoom_sel = '0;
    logic [7:0] color_out;
    logic       color_valid;
    logic [1:0] zoom_active;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   max_addr = 0;
    exp_t exp_q[$];

    zoom_window_reader_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

    zoom_window_reader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pixel_en   (pixel_en),
        .next_x     (next_x),
        .next_y     (next_y),
        .zoom_sel   (zoom_sel),
        .mem        (mem_if),
        .color_out  (color_out),
        .color_valid(color_valid),
        .zoom_active(zoom_active)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM content model: lane0 = addr^0x3C, lane1 = addr+0x11 (low byte).
    function automatic logic [7:0] ram_lane(input int addr, input int lane);
        logic [7:0] a;
        a = addr[7:0];
        return (lane == 0) ? (a ^ 8'h3C) : (a + 8'h11);
    endfunction

    always @(posedge clock)
        if (mem_if.rden) mem_if.q <= {ram_lane(int'(mem_if.addr), 0), ram_lane(int'(mem_if.addr), 1)};

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: pop and compare on every color_valid, including latency.
    always @(negedge clock) begin
        exp_t e;
        if (color_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected color_valid: got color 0x%0h want no output", color_out);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, " color"}, int'(color_out), int'(e.color));
                chk({e.tag, " latency"}, cyc - e.cyc, 2);
            end
        end
        if (mem_if.rden && int'(mem_if.addr) > max_addr) max_addr = int'(mem_if.addr);
    end

    task automatic send(input int x, input int y, input bit rd, input int addr, input int lane, input string tag);
        exp_t e;
        @(negedge clock);
        pixel_en = 1'b1;
        next_x   = 10'(x);
        next_y   = 10'(y);
        @(posedge clock);
        #1;
        e.cyc = cyc;
        e.tag = tag;
        chk({tag, " rden"}, int'(mem_if.rden), int'(rd));
        if (rd) begin
            chk({tag, " addr"}, int'(mem_if.addr), addr);
            e.color = ram_lane(addr, lane);
        end else begin
            e.color = BORDER;
        end
        exp_q.push_back(e);
        @(negedge clock);
        pixel_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1;
        chk("reset addr", int'(mem_if.addr), 0);
        chk("reset rden", int'(mem_if.rden), 0);
        chk("reset color", int'(color_out), 0);
        chk("reset valid", int'(color_valid), 0);
        chk("reset zoom", int'(zoom_active), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // 1x via reserved encoding.
        zoom_sel = 2'd3;
        send(0, 0, 0, 0, 0, "1x origin");
        chk("1x zoom_active", int'(zoom_active), 0);
        send(240, 180, 1, 0, 0, "1x 240");
        send(241, 180, 1, 0, 1, "1x 241");
        send(242, 180, 1, 1, 0, "1x 242");
        send(399, 180, 1, 79, 1, "1x lineend");
        send(240, 181, 1, 80, 0, "1x row1");
        send(400, 181, 0, 0, 0, "1x right");

        // 2x.
        zoom_sel = 2'd1;
        send(0, 0, 0, 0, 0, "2x origin");
        chk("2x zoom_active", int'(zoom_active), 1);
        send(160, 120, 1, 0, 0, "2x 160");
        send(161, 120, 1, 0, 0, "2x 161");
        send(162, 120, 1, 0, 1, "2x 162");
        send(164, 120, 1, 1, 0, "2x 164");
        send(479, 120, 1, 79, 1, "2x end120");
        send(479, 121, 1, 79, 1, "2x end121");
        send(160, 122, 1, 80, 0, "2x line122");
        zoom_sel = 2'd2;
        send(300, 200, 1, 115, 0, "2x 300_200");
        chk("zoom hold a", int'(zoom_active), 1);
        send(400, 200, 1, 140, 0, "2x 400_200");
        chk("zoom hold b", int'(zoom_active), 1);

        // 4x full-frame sweep: line start every 4th line, last column every line.
        send(0, 0, 1, 0, 0, "4x origin");
        chk("4x zoom_active", int'(zoom_active), 2);
        for (int y = 0; y < 480; y++) begin
            if (y % 4 == 0 && y != 0) send(0, y, 1, (y / 4) * 80, 0, "4x linestart");
            send(639, y, 1, (y / 4) * 80 + 79, 1, "4x lineend");
        end
        chk("4x last addr", int'(mem_if.addr), 9599);
        send(0, 0, 1, 0, 0, "4x origin again");
        drain();
        chk("4x max addr", max_addr, 9599);

        // Mid-frame reset.
        zoom_sel = 2'd1;
        send(0, 0, 0, 0, 0, "rst origin");
        send(300, 250, 1, 35, 0, "rst pre");
        drain();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst addr", int'(mem_if.addr), 0);
        chk("midrst rden", int'(mem_if.rden), 0);
        chk("midrst color", int'(color_out), 0);
        chk("midrst valid", int'(color_valid), 0);
        chk("midrst zoom", int'(zoom_active), 0);
        @(negedge clock);
        reset_n = 1'b1;
        send(300, 250, 0, 0, 0, "unarmed a");
        send(160, 120, 0, 0, 0, "unarmed b");
        send(200, 130, 0, 0, 0, "unarmed c");
        send(0, 0, 0, 0, 0, "rearm origin");
        send(160, 120, 1, 0, 0, "rearm 160");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
